// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Round-robin sharing of one SRAM write port and one read port
//               among NUM_REQ requesters, with read-after-write stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            wr_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]            wr_ready,
    input  logic [NUM_REQ-1:0]            rd_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_ready,
    output logic [NUM_REQ-1:0]            rd_resp_valid,
    output logic [DATA_WIDTH-1:0]         rd_resp_data,
    output logic [ADDR_WIDTH-1:0]         sram_write_address,
    output logic [DATA_WIDTH-1:0]         sram_write_data,
    output logic                          sram_write_enable,
    output logic [ADDR_WIDTH-1:0]         sram_read_address,
    input  logic [DATA_WIDTH-1:0]         sram_read_data,
    output logic [CNT_WIDTH-1:0]          hazard_stalls
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    // (base + offset) mod NUM_REQ, valid for offset < NUM_REQ
    function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base,
                                                   input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[c_IDX_W-1:0];
    endfunction

    // Returns {found, index}; scanning backwards lets the nearest requester win.
    function automatic logic [c_IDX_W:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [c_IDX_W-1:0] ptr);
        logic [c_IDX_W:0]   pick;
        logic [c_IDX_W-1:0] idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = f_wrap(ptr, k);
            if (valid[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    logic [c_IDX_W-1:0]    r_wr_ptr;
    logic [c_IDX_W-1:0]    r_rd_ptr;
    logic                  r_last_wr_en;
    logic [ADDR_WIDTH-1:0] r_last_wr_addr;
    logic [NUM_REQ-1:0]    r_resp_owner;
    logic [ADDR_WIDTH-1:0] r_rd_addr_hold;
    logic [CNT_WIDTH-1:0]  r_hazard_stalls;

    logic [c_IDX_W:0]      w_wr_pick;
    logic [c_IDX_W:0]      w_rd_pick;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_wr_grant;
    logic                  w_rd_found;
    logic                  w_rd_grant;
    logic                  w_hazard;
    logic [ADDR_WIDTH-1:0] w_cand_addr;

    assign w_wr_pick  = f_pick(wr_valid, r_wr_ptr);
    assign w_rd_pick  = f_pick(rd_valid, r_rd_ptr);
    assign w_wr_idx   = w_wr_pick[c_IDX_W-1:0];
    assign w_rd_idx   = w_rd_pick[c_IDX_W-1:0];
    assign w_wr_grant = reset & w_wr_pick[c_IDX_W];
    assign w_rd_found = reset & w_rd_pick[c_IDX_W];

    assign sram_write_address = wr_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sram_write_data    = wr_data[w_wr_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sram_write_enable  = w_wr_grant;
    assign wr_ready           = w_wr_grant ? (NUM_REQ'(1) << w_wr_idx) : '0;

    // The head-of-line read blocks behind both the write in flight this cycle
    // and the one committed last cycle; other readers are not skipped ahead.
    assign w_cand_addr = rd_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_hazard    = (w_wr_grant && (sram_write_address == w_cand_addr)) ||
                         (r_last_wr_en && (r_last_wr_addr == w_cand_addr));
    assign w_rd_grant  = w_rd_found & ~w_hazard;

    assign rd_ready          = w_rd_grant ? (NUM_REQ'(1) << w_rd_idx) : '0;
    assign sram_read_address = w_rd_grant ? w_cand_addr : r_rd_addr_hold;
    assign rd_resp_valid     = r_resp_owner;
    assign rd_resp_data      = sram_read_data;
    assign hazard_stalls     = r_hazard_stalls;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_last_wr_en    <= 1'b0;
            r_last_wr_addr  <= '0;
            r_resp_owner    <= '0;
            r_rd_addr_hold  <= '0;
            r_hazard_stalls <= '0;
        end else begin
            r_last_wr_en   <= sram_write_enable;
            r_last_wr_addr <= sram_write_address;
            r_resp_owner   <= rd_ready;
            if (w_wr_grant) r_wr_ptr <= f_wrap(w_wr_idx, 1);
            if (w_rd_grant) begin
                r_rd_ptr       <= f_wrap(w_rd_idx, 1);
                r_rd_addr_hold <= w_cand_addr;
            end
            if (w_rd_found && w_hazard && (r_hazard_stalls != '1))
                r_hazard_stalls <= r_hazard_stalls + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed self-checking bench for sram_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int c_N  = 4;
    localparam int c_AW = 32;
    localparam int c_DW = 16;
    localparam int c_CW = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [c_N-1:0]       wr_valid = '0;
    logic [c_N*c_AW-1:0]  wr_addr = '0;
    logic [c_N*c_DW-1:0]  wr_data = '0;
    logic [c_N-1:0]       wr_ready;
    logic [c_N-1:0]       rd_valid = '0;
    logic [c_N*c_AW-1:0]  rd_addr = '0;
    logic [c_N-1:0]       rd_ready;
    logic [c_N-1:0]       rd_resp_valid;
    logic [c_DW-1:0]      rd_resp_data;
    logic [c_AW-1:0]      sram_write_address;
    logic [c_DW-1:0]      sram_write_data;
    logic                 sram_write_enable;
    logic [c_AW-1:0]      sram_read_address;
    logic [c_DW-1:0]      sram_read_data = '0;
    logic [c_CW-1:0]      hazard_stalls;

    int checks = 0;
    int errors = 0;

    logic [c_DW-1:0] mem [0:255];

    always #5 clock = ~clock;

    sram_port_arbiter #(
        .NUM_REQ(c_N), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .sram_write_address(sram_write_address), .sram_write_data(sram_write_data),
        .sram_write_enable(sram_write_enable), .sram_read_address(sram_read_address),
        .sram_read_data(sram_read_data), .hazard_stalls(hazard_stalls)
    );

    // Registered-output SRAM model, cleared by its own reset
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            sram_read_data <= '0;
        end else begin
            if (sram_write_enable) mem[sram_write_address[7:0]] <= sram_write_data;
            sram_read_data <= mem[sram_read_address[7:0]];
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_all();
        wr_valid = '0;
        rd_valid = '0;
    endtask

    task automatic set_wr(input int i, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        wr_valid[i] = 1'b1;
        wr_addr[i*c_AW +: c_AW] = a;
        wr_data[i*c_DW +: c_DW] = d;
    endtask

    task automatic set_rd(input int i, input logic [c_AW-1:0] a);
        rd_valid[i] = 1'b1;
        rd_addr[i*c_AW +: c_AW] = a;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_all();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_wr(2, 32'h5, 16'h1);
        set_rd(3, 32'h6);
        @(negedge clock);
        checks++; if (wr_ready !== 4'b0000) begin errors++; $display("FAIL rst_wr_ready: got %b expected 0000", wr_ready); end
        checks++; if (rd_ready !== 4'b0000) begin errors++; $display("FAIL rst_rd_ready: got %b expected 0000", rd_ready); end
        checks++; if (sram_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", sram_write_enable); end
        next_cycle();
        @(negedge clock);
        checks++; if (rd_resp_valid !== 4'b0000) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0000", rd_resp_valid); end
        checks++; if (hazard_stalls !== 16'd0) begin errors++; $display("FAIL rst_stalls: got %0d expected 0", hazard_stalls); end
        checks++; if (sram_read_address !== 32'h0) begin errors++; $display("FAIL rst_rd_addr: got %h expected 0", sram_read_address); end
        do_reset();
    endtask

    task automatic test_write_read();
        do_reset();
        set_wr(0, 32'h10, 16'hBEEF);
        @(negedge clock);
        checks++; if (wr_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready: got %b expected 0001", wr_ready); end
        checks++; if (sram_write_enable !== 1'b1) begin errors++; $display("FAIL wr_enable: got %b expected 1", sram_write_enable); end
        checks++; if (sram_write_address !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h expected 10", sram_write_address); end
        checks++; if (sram_write_data !== 16'hBEEF) begin errors++; $display("FAIL wr_data: got %h expected beef", sram_write_data); end
        next_cycle();
        clear_all();
        repeat (3) next_cycle();
        set_rd(1, 32'h10);
        @(negedge clock);
        checks++; if (rd_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready: got %b expected 0010", rd_ready); end
        checks++; if (sram_read_address !== 32'h10) begin errors++; $display("FAIL rd_addr: got %h expected 10", sram_read_address); end
        next_cycle();
        clear_all();
        @(negedge clock);
        checks++; if (rd_resp_valid !== 4'b0010) begin errors++; $display("FAIL resp_valid: got %b expected 0010", rd_resp_valid); end
        checks++; if (rd_resp_data !== 16'hBEEF) begin errors++; $display("FAIL resp_data: got %h expected beef", rd_resp_data); end
        next_cycle();
    endtask

    task automatic test_round_robin_read();
        logic [3:0]  exp_g;
        logic [3:0]  exp_r;
        logic [15:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_wr(i, 32'h40 + i, 16'h1000 + 16'(i));
            next_cycle();
            clear_all();
        end
        next_cycle();
        for (int i = 0; i < 4; i++) set_rd(i, 32'h40 + i);
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            @(negedge clock);
            checks++; if (rd_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, rd_ready, exp_g); end
            if (k > 0) begin
                exp_r = 4'b0001 << ((k - 1) % 4);
                exp_d = 16'h1000 + 16'((k - 1) % 4);
                checks++; if (rd_resp_valid !== exp_r) begin errors++; $display("FAIL rr_resp%0d: got %b expected %b", k, rd_resp_valid, exp_r); end
                checks++; if (rd_resp_data !== exp_d) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, rd_resp_data, exp_d); end
            end
            next_cycle();
        end
        clear_all();
        @(negedge clock);
        checks++; if (rd_resp_valid !== 4'b0001) begin errors++; $display("FAIL rr_resp_last: got %b expected 0001", rd_resp_valid); end
        checks++; if (rd_resp_data !== 16'h1000) begin errors++; $display("FAIL rr_data_last: got %h expected 1000", rd_resp_data); end
        next_cycle();
    endtask

    task automatic test_hazard();
        do_reset();
        set_wr(0, 32'h20, 16'hCAFE);
        set_rd(2, 32'h20);
        @(negedge clock);
        checks++; if (wr_ready !== 4'b0001) begin errors++; $display("FAIL hz_wr_ready: got %b expected 0001", wr_ready); end
        checks++; if (rd_ready !== 4'b0000) begin errors++; $display("FAIL hz_rd_t0: got %b expected 0000", rd_ready); end
        next_cycle();
        wr_valid = '0;
        @(negedge clock);
        checks++; if (rd_ready !== 4'b0000) begin errors++; $display("FAIL hz_rd_t1: got %b expected 0000", rd_ready); end
        next_cycle();
        @(negedge clock);
        checks++; if (rd_ready !== 4'b0100) begin errors++; $display("FAIL hz_rd_t2: got %b expected 0100", rd_ready); end
        checks++; if (hazard_stalls !== 16'd2) begin errors++; $display("FAIL hz_stalls_t2: got %0d expected 2", hazard_stalls); end
        next_cycle();
        clear_all();
        @(negedge clock);
        checks++; if (rd_resp_valid !== 4'b0100) begin errors++; $display("FAIL hz_resp: got %b expected 0100", rd_resp_valid); end
        checks++; if (rd_resp_data !== 16'hCAFE) begin errors++; $display("FAIL hz_data: got %h expected cafe", rd_resp_data); end
        checks++; if (hazard_stalls !== 16'd2) begin errors++; $display("FAIL hz_stalls_end: got %0d expected 2", hazard_stalls); end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_wr(3, 32'h31, 16'h5678);
        next_cycle();
        clear_all();
        next_cycle();
        set_wr(0, 32'h30, 16'h1234);
        set_rd(1, 32'h31);
        @(negedge clock);
        checks++; if (wr_ready !== 4'b0001) begin errors++; $display("FAIL sim_wr_ready: got %b expected 0001", wr_ready); end
        checks++; if (rd_ready !== 4'b0010) begin errors++; $display("FAIL sim_rd_ready: got %b expected 0010", rd_ready); end
        next_cycle();
        clear_all();
        @(negedge clock);
        checks++; if (rd_resp_valid !== 4'b0010) begin errors++; $display("FAIL sim_resp: got %b expected 0010", rd_resp_valid); end
        checks++; if ($isunknown(rd_resp_data) || rd_resp_data !== 16'h5678) begin errors++; $display("FAIL sim_data: got %h expected 5678", rd_resp_data); end
        checks++; if (hazard_stalls !== 16'd0) begin errors++; $display("FAIL sim_stalls: got %0d expected 0", hazard_stalls); end
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_wr(0, 32'h50, 16'h1111);
        set_rd(2, 32'h50);
        next_cycle();
        wr_valid = '0;
        next_cycle();
        @(negedge clock);
        checks++; if (rd_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b expected 0100", rd_ready); end
        checks++; if (hazard_stalls !== 16'd2) begin errors++; $display("FAIL mid_stalls_pre: got %0d expected 2", hazard_stalls); end
        next_cycle();
        reset = 1'b0;
        set_wr(1, 32'h70, 16'h2222);
        @(negedge clock);
        checks++; if (rd_ready !== 4'b0000) begin errors++; $display("FAIL mid_rd_ready: got %b expected 0000", rd_ready); end
        checks++; if (wr_ready !== 4'b0000) begin errors++; $display("FAIL mid_wr_ready: got %b expected 0000", wr_ready); end
        checks++; if (sram_write_enable !== 1'b0) begin errors++; $display("FAIL mid_we: got %b expected 0", sram_write_enable); end
        next_cycle();
        @(negedge clock);
        checks++; if (rd_resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_resp: got %b expected 0000", rd_resp_valid); end
        checks++; if (hazard_stalls !== 16'd0) begin errors++; $display("FAIL mid_stalls: got %0d expected 0", hazard_stalls); end
        checks++; if (sram_read_address !== 32'h0) begin errors++; $display("FAIL mid_rd_addr: got %h expected 0", sram_read_address); end
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_rd(i, 32'h60 + i);
        @(negedge clock);
        checks++; if (rd_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_rd: got %b expected 0001", rd_ready); end
        checks++; if (wr_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_wr: got %b expected 0010", wr_ready); end
        next_cycle();
        clear_all();
    endtask

    task automatic test_back_to_back_writes();
        logic [3:0] exp_g;
        do_reset();
        set_wr(1, 32'h80, 16'hAAAA);
        set_wr(3, 32'h90, 16'hBBBB);
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 1) ? 4'b1000 : 4'b0010;
            @(negedge clock);
            checks++; if (wr_ready !== exp_g) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", k, wr_ready, exp_g); end
            checks++; if (sram_write_enable !== 1'b1) begin errors++; $display("FAIL b2b_we%0d: got %b expected 1", k, sram_write_enable); end
            next_cycle();
        end
        clear_all();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin_read();
        test_hazard();
        test_simultaneous();
        test_reset_mid_op();
        test_back_to_back_writes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
